// File: rtl/spi_regctrl.sv
`default_nettype none
// =============================================================================
// Module  : spi_regctrl
// Brief   : Framed register read/write controller sitting behind spislave.
// Revision: 1.0 - initial release
// =============================================================================
module spi_regctrl #(
   parameter int WIDTH    = 8,
   parameter int NREGS    = 16,
   parameter int ADDRBITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ss,
   input  logic [WIDTH-1:0]       rxdata,
   input  logic                   rxready,
   input  logic                   txready,
   input  logic [WIDTH-1:0]       status,
   output logic [WIDTH-1:0]       txdata,
   output logic [NREGS*WIDTH-1:0] regs_flat,
   output logic                   wr_strobe,
   output logic [ADDRBITS-1:0]    wr_addr,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CMD    = 3'd1,
      S_WRITE  = 3'd2,
      S_READ   = 3'd3,
      S_IGNORE = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_ss_s1, r_ss_s2, r_ss_q;
   logic                r_rxready_q;
   logic                r_byte_ev;
   logic [WIDTH-1:0]    r_rxbyte;
   logic                r_auto;
   logic [ADDRBITS-1:0] r_addr;
   logic [WIDTH-1:0]    r_regs [NREGS];
   logic [WIDTH-1:0]    r_txdata;
   logic                r_wr_strobe;
   logic [ADDRBITS-1:0] r_wr_addr;

   logic                w_frame_end;
   logic                w_rx_edge;
   logic                w_cmd_bad;
   logic [ADDRBITS-1:0] w_cmd_addr;
   logic [ADDRBITS-1:0] w_addr_next;

   assign w_frame_end = r_ss_s2 & ~r_ss_q;
   assign w_rx_edge   = rxready & ~r_rxready_q;
   assign w_cmd_bad   = int'(r_rxbyte[5:0]) >= NREGS;
   assign w_cmd_addr  = r_rxbyte[ADDRBITS-1:0];

   always_comb begin
      w_addr_next = r_addr;
      if (r_auto)
         w_addr_next = (r_addr == ADDRBITS'(NREGS-1)) ? '0 : r_addr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ss_s1     <= 1'b1;
         r_ss_s2     <= 1'b1;
         r_ss_q      <= 1'b1;
         r_rxready_q <= 1'b0;
         r_byte_ev   <= 1'b0;
         r_rxbyte    <= '0;
         r_auto      <= 1'b0;
         r_addr      <= '0;
         r_txdata    <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_state     <= S_IDLE;
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else begin
         r_ss_s1     <= ss;
         r_ss_s2     <= r_ss_s1;
         r_ss_q      <= r_ss_s2;
         r_rxready_q <= rxready;
         r_byte_ev   <= w_rx_edge;
         if (w_rx_edge)
            r_rxbyte <= rxdata;
         r_wr_strobe <= 1'b0;

         // Frame end wins over a coincident byte event, which is dropped.
         if (w_frame_end) begin
            r_state  <= S_IDLE;
            r_txdata <= status;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_txdata <= status;
                  if (!r_ss_s2)
                     r_state <= S_CMD;
               end
               S_CMD: begin
                  if (r_byte_ev) begin
                     r_auto <= r_rxbyte[6];
                     r_addr <= w_cmd_addr;
                     if (w_cmd_bad) begin
                        r_state  <= S_IGNORE;
                        r_txdata <= '0;
                     end else if (!r_rxbyte[7]) begin
                        r_state  <= S_WRITE;
                        r_txdata <= '0;
                     end else begin
                        r_state  <= S_READ;
                        r_txdata <= r_regs[w_cmd_addr];
                     end
                  end
               end
               S_WRITE: begin
                  r_txdata <= '0;
                  if (r_byte_ev) begin
                     r_regs[r_addr] <= r_rxbyte;
                     r_wr_strobe    <= 1'b1;
                     r_wr_addr      <= r_addr;
                     r_addr         <= w_addr_next;
                  end
               end
               S_READ: begin
                  if (r_byte_ev) begin
                     r_addr   <= w_addr_next;
                     r_txdata <= r_regs[w_addr_next];
                  end
               end
               S_IGNORE: r_txdata <= '0;
               default: begin
                  r_state  <= S_IDLE;
                  r_txdata <= '0;
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
   end

   assign txdata    = r_txdata;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign busy      = ~r_ss_s2;

`ifndef SYNTHESIS
   // Sticky: slave captured txdata while a post-byte update was still in flight.
   logic sim_underrun;
   always_ff @(posedge clk) begin
      if (rst)
         sim_underrun <= 1'b0;
      else if (txready && (w_rx_edge || r_byte_ev))
         sim_underrun <= 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_spi_regctrl
// Brief   : Byte-level spislave emulation driving spi_regctrl with directed frames.
// Revision: 1.0 - initial release
// =============================================================================
module tb_spi_regctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ss = 1'b1;
   logic [7:0]   rxdata = '0;
   logic         rxready = 1'b0;
   logic         txready = 1'b0;
   logic [7:0]   status = 8'h5A;
   logic [7:0]   txdata;
   logic [127:0] regs_flat;
   logic         wr_strobe;
   logic [3:0]   wr_addr;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] wr_q[$];

   spi_regctrl #(.WIDTH(8), .NREGS(16), .ADDRBITS(4)) dut (
      .clk(clk), .rst(rst), .ss(ss), .rxdata(rxdata), .rxready(rxready),
      .txready(txready), .status(status), .txdata(txdata),
      .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (wr_strobe === 1'b1) wr_q.push_back(wr_addr);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Frame vector: status, byte count, MOSI bytes (MSB first), expected MISO,
   // expected strobe count, expected strobe addresses (nibbles, MSB first).
   typedef struct {
      logic [7:0]  st;
      int          n;
      logic [31:0] mosi;
      logic [31:0] miso;
      int          ns;
      logic [11:0] addrs;
   } frame_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One byte as spislave presents it: capture txdata, shift 8 bits, raise rxready.
   task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
      txready = 1'b1;
      @(negedge clk) miso = txdata;
      @(posedge clk) #1 txready = 1'b0;
      repeat (60) @(posedge clk);
      #1 rxdata = mosi; rxready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rxready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      ss = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic frame_stop();
      ss = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [7:0] exp[16]);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s reg%0d", tag, i), 32'(regs_flat[i*8 +: 8]), 32'(exp[i]));
   endtask

   initial begin
      frame_t     tbl[6];
      logic [7:0] exp_regs[16];
      logic [7:0] m;
      int         cyc;

      tbl[0] = '{8'h5A, 4, 32'h45112233, 32'h5A000000, 3, 12'h567};
      tbl[1] = '{8'h3C, 4, 32'h4EAABBCC, 32'h3C000000, 3, 12'hEF0};
      tbl[2] = '{8'h81, 4, 32'hCE000000, 32'h81AABBCC, 0, 12'h000};
      tbl[3] = '{8'h5A, 4, 32'h03010203, 32'h5A000000, 3, 12'h333};
      tbl[4] = '{8'h7E, 2, 32'h20550000, 32'h7E000000, 0, 12'h000};
      tbl[5] = '{8'h5A, 3, 32'h85000000, 32'h5A111100, 0, 12'h000};
      exp_regs = '{8'hCC, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst txdata", 32'(txdata), 32'h0);
      check("rst regs_flat", 32'(regs_flat != '0), 32'h0);
      check("rst wr_strobe", 32'(wr_strobe), 32'h0);
      check("rst wr_addr", 32'(wr_addr), 32'h0);
      check("rst busy", 32'(busy), 32'h0);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle txdata=status", 32'(txdata), 32'h5A);

      // Table-driven frames
      for (int f = 0; f < 6; f++) begin
         status = tbl[f].st;
         wr_q.delete();
         frame_start();
         check($sformatf("f%0d busy", f), 32'(busy), 32'h1);
         for (int k = 0; k < tbl[f].n; k++) begin
            xfer(tbl[f].mosi[31-8*k -: 8], m);
            check($sformatf("f%0d miso%0d", f, k), 32'(m), 32'(tbl[f].miso[31-8*k -: 8]));
         end
         frame_stop();
         check($sformatf("f%0d busy after", f), 32'(busy), 32'h0);
         check($sformatf("f%0d strobes", f), wr_q.size(), 32'(tbl[f].ns));
         for (int k = 0; k < tbl[f].ns && k < wr_q.size(); k++)
            check($sformatf("f%0d wr_addr%0d", f, k), 32'(wr_q[k]), 32'(tbl[f].addrs[11-4*k -: 4]));
      end
      check_regs("tbl", exp_regs);

      // Early SS release mid data byte: no write, back to idle quickly
      status = 8'h5A;
      wr_q.delete();
      frame_start();
      xfer(8'h41, m);
      check("early miso0", 32'(m), 32'h5A);
      txready = 1'b1;
      @(posedge clk) #1 txready = 1'b0;
      repeat (32) @(posedge clk);
      #1 ss = 1'b1;
      cyc = 0;
      while (busy && cyc < 3) begin
         @(posedge clk) #1;
         cyc++;
      end
      check("early busy low", 32'(busy), 32'h0);
      repeat (6) @(posedge clk);
      #1;
      check("early reg1", 32'(regs_flat[15:8]), 32'h0);
      check("early strobes", wr_q.size(), 32'h0);
      frame_start();
      xfer(8'h41, m);
      check("next miso0", 32'(m), 32'h5A);
      xfer(8'h99, m);
      check("next miso1", 32'(m), 32'h0);
      frame_stop();
      check("next reg1", 32'(regs_flat[15:8]), 32'h99);
      check("next strobes", wr_q.size(), 32'h1);
      if (wr_q.size() > 0) check("next wr_addr", 32'(wr_q[0]), 32'h1);
      check("underrun pre-reset", 32'(dut.sim_underrun), 32'h0);

      // Reset mid-frame; SS stays low so the next byte is a command
      wr_q.delete();
      frame_start();
      xfer(8'h42, m);
      txready = 1'b1;
      @(posedge clk) #1 txready = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk) #1 rst = 1'b0;
      @(negedge clk);
      check("mid rst txdata", 32'(txdata), 32'h0);
      check("mid rst busy", 32'(busy), 32'h0);
      check("mid rst regs", 32'(regs_flat != '0), 32'h0);
      cyc = 0;
      while (!busy && cyc < 4) begin
         @(negedge clk);
         cyc++;
      end
      check("mid rst busy again", 32'(busy), 32'h1);
      repeat (4) @(posedge clk);
      #1;
      xfer(8'h41, m);
      check("post rst miso0", 32'(m), 32'h5A);
      xfer(8'h66, m);
      check("post rst miso1", 32'(m), 32'h0);
      frame_stop();
      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      exp_regs[1] = 8'h66;
      check_regs("post rst", exp_regs);
      check("post rst strobes", wr_q.size(), 32'h1);
      check("underrun final", 32'(dut.sim_underrun), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_regctrl.md
# spi_regctrl

Register-access controller that sits directly behind `spislave` (WIDTH=8) and turns its raw byte stream into a framed command protocol. It owns a bank of NREGS configuration registers that drive the pulse-generation logic. Each SPI frame (SS low) carries one command byte, followed by any number of data bytes that are written into or read from consecutive registers. It also sequences `txdata` so that every read byte is presented to the slave before the slave captures it.

## Interface
- `WIDTH`, 8: byte width; must match the `spislave` instance.
- `NREGS`, 16: number of registers; range 2..64.
- `ADDRBITS`, 4: register index width; must equal clog2(NREGS).
- `clk`  in  1  system clock, the same clock as `spislave`.
- `rst`  in  1  reset, synchronous and active-high.
- `ss`  in  1  raw active-low slave select, from the pin; synchronised internally.
- `rxdata`  in  WIDTH  received byte, from `spislave`.
- `rxready`  in  1  byte-valid level, from `spislave`.
- `txready`  in  1  `spislave` is capturing `txdata` this cycle.
- `status`  in  WIDTH  live status byte, returned as the first MISO byte of every frame.
- `txdata`  out  WIDTH  next byte to shift out, to `spislave`.
- `regs_flat`  out  NREGS*WIDTH  register bank; register i occupies bits [i*WIDTH +: WIDTH].
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  ADDRBITS  index of the register just written; valid with `wr_strobe`.
- `busy`  out  1  high while a frame is active (synchronised SS low).

## Operation
- **SS handling.** SS passes through a 2-flop synchroniser. `frame_end` is the rising edge of the synchronised SS.
- **Byte events.** `byte_ev = rxready & ~rxready_q`. Exactly one event occurs per received byte, even if `rxready` stays high for more than one cycle.
- **Command byte.**
  - cmd[7] selects the access: 1 = read, 0 = write.
  - cmd[6] = auto-increment.
  - cmd[5:0] = start address.
- **FSM states:** IDLE, CMD, WRITE, READ, IGNORE.
- **IDLE**
  - `txdata` = `status`, re-registered every cycle.
  - Synchronised SS low → CMD.
- **CMD**
  - `txdata` is frozen at the `status` value registered on entry.
  - On `byte_ev`: latch address and auto-increment.
  - cmd[5:0] ≥ NREGS → IGNORE.
  - Otherwise cmd[7]=0 → WRITE.
  - Otherwise cmd[7]=1 → READ, and `txdata` ← reg[addr].
- **WRITE**
  - On `byte_ev`: reg[addr] ← `rxdata`, `wr_strobe`=1, `wr_addr`=addr.
  - Then addr advances if auto-increment is set.
  - `txdata` = 0.
- **READ**
  - Received bytes are don't-care.
  - On `byte_ev`: advance addr if auto-increment is set, then `txdata` ← reg[new addr].
  - The value is registered one cycle after `byte_ev`.
- **IGNORE**
  - No writes; `txdata` = 0 until `frame_end`.
- **Address increment** wraps NREGS-1 → 0. With auto-increment clear, the same register is repeatedly accessed.
- **`frame_end` in any state** → IDLE.
  - Any partial byte is discarded; `spislave` clears itself.
  - Takes priority over a simultaneous `byte_ev`, which is dropped.
- **`txready`** is used only for assertion checking. If `txready` pulses while the post-`byte_ev` `txdata` update is still pending, the sticky `sim_underrun` flag is set. This is a non-synthesised debug signal.
- **Reset** (`rst`, mid-frame or not):
  - All registers → 0, FSM → IDLE, `txdata` → 0 for the reset cycle, `wr_strobe` → 0, `busy` → 0, addr → 0.
  - If SS is still low after reset releases, the controller re-enters CMD. The next received byte is treated as a command, so the master must restart the frame.

## Timing
- `byte_ev` lags `rxready` rising by 1 cycle (edge register). Register write takes effect at the clock edge ending the `byte_ev` cycle.
- `wr_strobe` is asserted in the cycle after `byte_ev`; `regs_flat` shows the new value in that same cycle.
- READ `txdata` is valid 2 cycles after `rxready` rises.
- Constraint: SCK half-period ≥ 4 `clk` cycles. This keeps `txdata` stable before the next leading-edge capture, given the 3-cycle `spislave` synchroniser slack.
- `busy` = synchronised SS low; 2-cycle latency from the pin.
- Reset values: `txdata`=0, `regs_flat`=0, `wr_strobe`=0, `wr_addr`=0, `busy`=0.

## Test plan
- Write burst: frame of bytes 0x45,0x11,0x22,0x33 (write, auto-increment, address 5) → reg5=0x11, reg6=0x22, reg7=0x33; three `wr_strobe` pulses with `wr_addr` 5,6,7; MISO returns `status`, then 0,0,0.
- Read with wrap: preload reg14=0xAA, reg15=0xBB, reg0=0xCC; frame 0xCE,x,x,x (read, auto-increment, address 14) → MISO `status`,0xAA,0xBB,0xCC; no `wr_strobe`.
- No auto-increment: frame 0x03,0x01,0x02,0x03 → reg3=0x03 at end of frame; 3 `wr_strobe` pulses, all with `wr_addr`=3.
- Bad address: frame 0x20,0x55 with NREGS=16 → IGNORE; no register changes; MISO `status`,0x00.
- Early SS release: drop SS after 4 bits of the second byte of a write frame → no write; IDLE within 3 cycles; the next frame decodes normally.
- Reset mid-frame: assert `rst` for 1 cycle during the data byte of a write frame → all registers 0, FSM IDLE then CMD; with SCK half-period = 4 `clk`, `sim_underrun` never set across all scenarios.
